// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response, core redirect, and decode handoff.
// The master modport is the fetch unit; the slave modport is the memory/core/decode side.
interface instr_fetch_if #(
    parameter int unsigned BIT_COUNT = 32
);
    logic [BIT_COUNT-1:0] InstrAdr;
    logic                 ReqValid;
    logic                 ReqReady;
    logic                 RespValid;
    logic [31:0]          RespInstr;
    logic                 Redirect;
    logic [BIT_COUNT-1:0] RedirectAdr;
    logic                 InstrValid;
    logic [31:0]          Instr;
    logic [BIT_COUNT-1:0] InstrPC;
    logic                 InstrReady;

    modport master (
        output InstrAdr, ReqValid, InstrValid, Instr, InstrPC,
        input  ReqReady, RespValid, RespInstr, Redirect, RedirectAdr, InstrReady
    );

    modport slave (
        input  InstrAdr, ReqValid, InstrValid, Instr, InstrPC,
        output ReqReady, RespValid, RespInstr, Redirect, RedirectAdr, InstrReady
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests, queues returned
// instructions in order for decode, and flushes/drops in-flight work on redirect.
module instr_fetch_unit #(
    parameter int unsigned          BIT_COUNT    = 32,
    parameter logic [BIT_COUNT-1:0] RESET_VECTOR = '0,
    parameter int unsigned          QUEUE_DEPTH  = 2
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [BIT_COUNT-1:0] pc;
        logic [31:0]          instr;
    } queueEntry_t;

    logic [BIT_COUNT-1:0] fetchPC;
    logic [BIT_COUNT-1:0] tagMem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     tagWrPtr;
    logic [PTR_W-1:0]     tagRdPtr;
    queueEntry_t          queueMem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     qWrPtr;
    logic [PTR_W-1:0]     qRdPtr;
    logic [CNT_W-1:0]     qCount;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     dropCnt;

    logic creditOk;
    logic reqFire;
    logic respFire;
    logic pushQ;
    logic popQ;

    // Every request in flight already owns a queue slot, so responses can never overflow it.
    assign creditOk = (SUM_W'(qCount) + SUM_W'(outstanding)) < SUM_W'(QUEUE_DEPTH);
    assign bus.ReqValid = reset & !bus.Redirect & (dropCnt == '0) & creditOk;
    assign reqFire  = bus.ReqValid & bus.ReqReady;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign respFire = bus.RespValid & (outstanding != '0);
    assign pushQ    = respFire & (dropCnt == '0) & !bus.Redirect;
    assign popQ     = bus.InstrValid & bus.InstrReady;

    assign bus.InstrAdr   = fetchPC;
    assign bus.InstrValid = (qCount != '0);
    assign bus.Instr      = queueMem[qRdPtr].instr;
    assign bus.InstrPC    = queueMem[qRdPtr].pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPC     <= RESET_VECTOR;
            tagWrPtr    <= '0;
            tagRdPtr    <= '0;
            qWrPtr      <= '0;
            qRdPtr      <= '0;
            qCount      <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                tagMem[i]   <= '0;
                queueMem[i] <= '0;
            end
        end else begin
            // The PC tag FIFO tracks every request until its response returns, even across redirects.
            if (reqFire) begin
                tagMem[tagWrPtr] <= fetchPC;
                tagWrPtr         <= tagWrPtr + PTR_W'(1);
            end
            if (respFire) begin
                tagRdPtr <= tagRdPtr + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(reqFire) - CNT_W'(respFire);

            if (bus.Redirect) begin
                // Everything still in flight belongs to the abandoned stream.
                fetchPC <= bus.RedirectAdr & ~BIT_COUNT'(3);
                dropCnt <= outstanding - CNT_W'(respFire);
                qWrPtr  <= '0;
                qRdPtr  <= '0;
                qCount  <= '0;
            end else begin
                if (reqFire) begin
                    fetchPC <= fetchPC + BIT_COUNT'(4);
                end
                if (respFire && (dropCnt != '0)) begin
                    dropCnt <= dropCnt - CNT_W'(1);
                end
                if (pushQ) begin
                    queueMem[qWrPtr] <= '{pc: tagMem[tagRdPtr], instr: bus.RespInstr};
                    qWrPtr           <= qWrPtr + PTR_W'(1);
                end
                if (popQ) begin
                    qRdPtr <= qRdPtr + PTR_W'(1);
                end
                qCount <= qCount + CNT_W'(pushQ) - CNT_W'(popQ);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-configurable memory model answers requests,
// expected {PC, word} pairs are queued at request accept and compared when decode pops them.
module tb_instr_fetch_unit;
    logic clk;
    logic reset;

    instr_fetch_if #(.BIT_COUNT(32)) bus ();

    instr_fetch_unit #(
        .BIT_COUNT   (32),
        .RESET_VECTOR(32'h0),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] adr;
        int          due;
    } memReq_t;

    exp_t        expQ [$];
    memReq_t     memPend [$];
    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    int          accCnt;
    int          firstAcc;
    int          firstPop;
    logic [31:0] modelPC;
    logic [31:0] firstPopPC;
    logic [31:0] lastAcc;
    logic [31:0] prevAcc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: memory answers, handshakes are scored before the edge, then back to the negedge.
    task automatic step();
        exp_t    e;
        memReq_t m;
        bus.RespValid = 1'b0;
        bus.RespInstr = '0;
        if (memPend.size() != 0 && memPend[0].due <= cyc) begin
            bus.RespValid = 1'b1;
            bus.RespInstr = memWord(memPend[0].adr);
            void'(memPend.pop_front());
        end
        #1;
        if (bus.InstrValid && bus.InstrReady) begin
            if (expQ.size() == 0) begin
                chk("pop_extra", 1, 0);
            end else begin
                e = expQ.pop_front();
                chk("instr", bus.Instr, e.instr);
                chk("instr_pc", bus.InstrPC, e.pc);
            end
            if (firstPop < 0) begin
                firstPop   = cyc;
                firstPopPC = bus.InstrPC;
            end
        end
        if (bus.ReqValid && bus.ReqReady) begin
            chk("req_adr", bus.InstrAdr, modelPC);
            m.adr = bus.InstrAdr;
            m.due = cyc + lat;
            memPend.push_back(m);
            e.pc    = modelPC;
            e.instr = memWord(modelPC);
            expQ.push_back(e);
            modelPC = modelPC + 32'd4;
            accCnt++;
            prevAcc = lastAcc;
            lastAcc = bus.InstrAdr;
            if (firstAcc < 0) firstAcc = cyc;
        end
        if (bus.Redirect) begin
            expQ.delete();
            modelPC = bus.RedirectAdr & ~32'h3;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic doReset();
        #2 reset = 1'b0;
        #1;
        chk("rst_instr_valid", bus.InstrValid, 0);
        chk("rst_req_valid", bus.ReqValid, 0);
        chk("rst_instr_adr", bus.InstrAdr, 0);
        chk("rst_instr", bus.Instr, 0);
        chk("rst_instr_pc", bus.InstrPC, 0);
        memPend.delete();
        expQ.delete();
        modelPC  = 32'h0;
        accCnt   = 0;
        firstAcc = -1;
        firstPop = -1;
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic redirectTo(input logic [31:0] target);
        bus.Redirect    = 1'b1;
        bus.RedirectAdr = target;
        step();
        bus.Redirect    = 1'b0;
    endtask

    initial begin
        int a0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        lat    = 1;
        reset  = 1'b1;
        bus.ReqReady    = 1'b1;
        bus.RespValid   = 1'b0;
        bus.RespInstr   = '0;
        bus.Redirect    = 1'b0;
        bus.RedirectAdr = '0;
        bus.InstrReady  = 1'b1;
        doReset();

        // Streaming with a 1-cycle memory and decode always ready.
        for (int i = 0; i < 12; i++) step();
        chk("t1_first_req_cycle", firstAcc, 0);
        chk("t1_first_valid_lat", firstPop - firstAcc, 2);

        // Decode stalled: credits stop fetch after two requests.
        doReset();
        bus.InstrReady = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #1;
        chk("t2_req_count", accCnt, 2);
        chk("t2_req_valid_held", bus.ReqValid, 0);
        chk("t2_head_valid", bus.InstrValid, 1);
        chk("t2_head_pc", bus.InstrPC, 32'h0);
        chk("t2_head_instr", bus.Instr, memWord(32'h0));
        bus.InstrReady = 1'b1;
        step();
        bus.InstrReady = 1'b0;
        #1;
        chk("t2_req_after_pop", bus.ReqValid, 1);
        chk("t2_adr_after_pop", bus.InstrAdr, 32'h8);
        step();
        chk("t2_req_count2", accCnt, 3);
        bus.InstrReady = 1'b1;

        // 3-cycle memory, two in flight, redirect to an unaligned target.
        doReset();
        lat = 3;
        step();
        step();
        #1;
        chk("t3_credit_stall", bus.ReqValid, 0);
        redirectTo(32'h103);
        #1;
        chk("t3_drop1_req", bus.ReqValid, 0);
        chk("t3_drop1_valid", bus.InstrValid, 0);
        step();
        #1;
        chk("t3_drop2_req", bus.ReqValid, 0);
        chk("t3_drop2_valid", bus.InstrValid, 0);
        step();
        #1;
        chk("t3_resume_req", bus.ReqValid, 1);
        chk("t3_resume_adr", bus.InstrAdr, 32'h100);
        firstPop = -1;
        for (int i = 0; i < 20 && firstPop < 0; i++) step();
        chk("t3_first_pc", firstPopPC, 32'h100);

        // Redirect coinciding with the only outstanding response.
        lat = 1;
        for (int i = 0; i < 20 && !(memPend.size() == 1 && memPend[0].due <= cyc); i++) step();
        chk("t4_setup", (memPend.size() == 1 && memPend[0].due <= cyc), 1);
        redirectTo(32'h2000);
        #1;
        chk("t4_restart_req", bus.ReqValid, 1);
        chk("t4_restart_adr", bus.InstrAdr, 32'h2000);
        for (int i = 0; i < 6; i++) step();

        // PC wraps past the top of the address space.
        redirectTo(32'hFFFF_FFFE);
        a0 = accCnt;
        for (int i = 0; i < 30 && accCnt < a0 + 2; i++) step();
        chk("t5_wrap_pre", prevAcc, 32'hFFFF_FFFC);
        chk("t5_wrap_adr", lastAcc, 32'h0);

        // Random backpressure and redirects on a 2-cycle memory.
        lat = 2;
        for (int i = 0; i < 200; i++) begin
            bus.ReqReady   = 1'($urandom_range(0, 1));
            bus.InstrReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) redirectTo($urandom());
            else step();
        end
        bus.ReqReady   = 1'b0;
        bus.InstrReady = 1'b1;
        for (int i = 0; i < 40 && (expQ.size() != 0 || memPend.size() != 0); i++) step();
        chk("drain_left", expQ.size(), 0);
        bus.ReqReady = 1'b1;

        // Asynchronous reset with a full queue.
        bus.InstrReady = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #1;
        chk("t6_full_valid", bus.InstrValid, 1);
        doReset();
        bus.InstrReady = 1'b1;
        lat = 1;
        for (int i = 0; i < 10; i++) step();
        chk("t6_restart_cycle", firstAcc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the compute core's decode input, between the core and the instruction-side vectorStorage.
- Owns the fetch PC and issues word requests to instruction memory over a request/response handshake.
- Buffers returned instructions in a small in-order queue.
- Presents them to decode with a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding in-flight responses.

Parameters:
BIT_COUNT, 32, width of instruction addresses and PC
RESET_VECTOR, 0, fetch PC after reset (low 2 bits must be 0)
QUEUE_DEPTH, 2, instruction queue entries; power of 2, >= 2; also the cap on outstanding requests

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
InstrAdr  output  BIT_COUNT  request address to instruction memory (current fetch PC)
ReqValid  output  1  request valid
ReqReady  input  1  memory accepts request; transfer when ReqValid & ReqReady
RespValid  input  1  one response word this cycle, always in request order
RespInstr  input  32  response instruction word
Redirect  input  1  from core: discard the sequential stream, fetch from RedirectAdr
RedirectAdr  input  BIT_COUNT  redirect target
InstrValid  output  1  queue head valid toward decode
Instr  output  32  queue head instruction
InstrPC  output  BIT_COUNT  address of queue head instruction
InstrReady  input  1  decode accepts head; pop when InstrValid & InstrReady

Behaviour:
- Reset (reset=0, asynchronous):
  - FetchPC=RESET_VECTOR, queue empty, Outstanding=0, DropCnt=0.
  - ReqValid=0, InstrValid=0, Instr=0, InstrPC=0.
  - The first request may issue in the first cycle after reset deasserts.
- Credit rule: ReqValid = !Redirect & (DropCnt==0) & (QueueCount + Outstanding < QUEUE_DEPTH). Every accepted response therefore has a queue slot; the queue never overflows.
- Request accept: FetchPC <= FetchPC + 4, wrapping modulo 2^BIT_COUNT. Each request's PC is pushed into an in-order PC tag FIFO of QUEUE_DEPTH entries.
- Response:
  - If DropCnt>0, decrement DropCnt and discard the word and its PC tag.
  - Otherwise push {tag PC, RespInstr} into the queue.
  - Outstanding decrements in both cases.
  - RespValid with Outstanding==0 is a protocol error; ignore it (no state change).
- Output: InstrValid = queue not empty. Instr/InstrPC come from the head entry and are stable while InstrValid & !InstrReady. Minimum latency from response to InstrValid is 1 cycle (registered queue; no bypass).
- Same cycle push and pop: both occur and the count is unchanged. A full queue with a pop and a push in the same cycle is legal.
- Redirect (highest priority):
  - Queue flushed next cycle.
  - FetchPC <= {RedirectAdr[BIT_COUNT-1:2], 2'b00}.
  - DropCnt <= Outstanding + (ReqValid&ReqReady ? 1 : 0) - (RespValid ? 1 : 0). ReqValid is 0 on redirect, so the second term is 0.
  - A response arriving in the redirect cycle is discarded.
  - An InstrReady handshake in the redirect cycle counts as consumed; no further entries from the old stream are ever presented.
- Back-to-back redirects: the later one wins. DropCnt is recomputed from the current Outstanding, so counting stays exact.
- Fetch resumes when DropCnt==0. If nothing is in flight, the first request at the new PC issues in the cycle after Redirect.
- Counter widths: Outstanding and DropCnt are clog2(QUEUE_DEPTH)+1 bits and never exceed QUEUE_DEPTH.
- Reset mid-operation: all in-flight state clears immediately. Responses arriving after reset release, for requests made before reset, are the memory's responsibility and must not occur.

Test Plan:
- Reset release, 1-cycle memory, InstrReady=1 -> requests at 0x0,0x4,0x8,... back-to-back; Instr/InstrPC pairs appear in order, first InstrValid 2 cycles after first accept.
- InstrReady=0 held with QUEUE_DEPTH=2 -> exactly 2 requests issued, then ReqValid=0. Head holds PC 0x0 stable. Raising InstrReady pops 0x0 and one new request issues the next cycle.
- 3-cycle memory latency, 2 requests in flight, Redirect to 0x103 -> both late responses discarded (DropCnt 2->0). Next request InstrAdr=0x100, and the first InstrPC presented is 0x100.
- Redirect and RespValid in the same cycle with Outstanding=1 -> DropCnt=0, response discarded, fetch restarts at the target the next cycle.
- FetchPC=0xFFFFFFFC with BIT_COUNT=32 -> next request InstrAdr=0x00000000.
- Assert reset with the queue full and 2 requests outstanding -> InstrValid=0 and ReqValid=0 immediately (asynchronous), InstrAdr=RESET_VECTOR.
